// File: rtl/regfile_ctrl.sv
// Sequencer driving the 8x4 register file: single writes, a fill burst over
// every address, and a timed read-address scan for the display.
module regfile_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 4,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic              btn_wr,
    input  logic              btn_fill,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_din,
    output logic              rf_load,
    output logic              busy
);

    localparam int TMR_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  fill_idx, fill_idx_next;
    logic [DATA_W-1:0]  sw_data_lat, sw_data_lat_next;
    logic [TMR_W-1:0]   scan_tmr, scan_tmr_next;
    logic [ADDR_W-1:0]  scan_addr, scan_addr_next;
    logic               btn_wr_q, btn_fill_q;
    logic               wr_edge, fill_edge;
    logic [ADDR_W-1:0]  rf_addr_next;
    logic [DATA_W-1:0]  rf_din_next;
    logic               rf_load_next, busy_next;

    assign wr_edge   = btn_wr & ~btn_wr_q;
    assign fill_edge = btn_fill & ~btn_fill_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next       = state;
        fill_idx_next    = fill_idx;
        sw_data_lat_next = sw_data_lat;
        scan_tmr_next    = scan_tmr;
        scan_addr_next   = scan_addr;
        rf_addr_next     = '0;
        rf_din_next      = '0;
        rf_load_next     = 1'b0;
        busy_next        = 1'b0;

        // Disabling the scan wins over the hold in WRITE/FILL so a re-enable always starts at 0.
        if (!scan_en) begin
            scan_tmr_next  = '0;
            scan_addr_next = '0;
        end else if (state == IDLE) begin
            if (scan_tmr == TMR_LAST) begin
                scan_tmr_next  = '0;
                scan_addr_next = scan_addr + ADDR_W'(1);
            end else begin
                scan_tmr_next = scan_tmr + TMR_W'(1);
            end
        end

        case (state)
            IDLE: begin
                if (fill_edge) begin
                    state_next       = FILL;
                    fill_idx_next    = '0;
                    sw_data_lat_next = sw_data;
                end else if (wr_edge) begin
                    state_next = WRITE;
                end
            end
            WRITE: state_next = IDLE;
            FILL: begin
                if (fill_idx == ADDR_LAST) begin
                    state_next    = IDLE;
                    fill_idx_next = '0;
                end else begin
                    fill_idx_next = fill_idx + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the state being entered, then registered.
        case (state_next)
            WRITE: begin
                rf_addr_next = sw_addr;
                rf_din_next  = sw_data;
                rf_load_next = 1'b1;
                busy_next    = 1'b1;
            end
            FILL: begin
                rf_addr_next = fill_idx_next;
                rf_din_next  = sw_data_lat_next + DATA_W'(fill_idx_next);
                rf_load_next = 1'b1;
                busy_next    = 1'b1;
            end
            default: begin
                rf_addr_next = scan_en ? scan_addr_next : sw_addr;
                rf_din_next  = sw_data;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            fill_idx    <= '0;
            sw_data_lat <= '0;
            scan_tmr    <= '0;
            scan_addr   <= '0;
            btn_wr_q    <= 1'b1;
            btn_fill_q  <= 1'b1;
            rf_addr     <= '0;
            rf_din      <= '0;
            rf_load     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            fill_idx    <= fill_idx_next;
            sw_data_lat <= sw_data_lat_next;
            scan_tmr    <= scan_tmr_next;
            scan_addr   <= scan_addr_next;
            btn_wr_q    <= btn_wr;
            btn_fill_q  <= btn_fill;
            rf_addr     <= rf_addr_next;
            rf_din      <= rf_din_next;
            rf_load     <= rf_load_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a short scan period (SCAN_DIV=4).
module tb_regfile_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] sw_data;
    logic [2:0] sw_addr;
    logic       btn_wr, btn_fill, scan_en;
    logic [2:0] rf_addr;
    logic [3:0] rf_din;
    logic       rf_load, busy;

    int checks = 0;
    int failures = 0;
    int ticks;

    regfile_ctrl #(.ADDR_W(3), .DATA_W(4), .SCAN_DIV(4)) dut (
        .clk(clk), .clr(clr), .sw_data(sw_data), .sw_addr(sw_addr),
        .btn_wr(btn_wr), .btn_fill(btn_fill), .scan_en(scan_en),
        .rf_addr(rf_addr), .rf_din(rf_din), .rf_load(rf_load), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] a, input logic [3:0] d,
                           input logic ld, input logic b);
        check({tag, ".addr"}, 32'(rf_addr), 32'(a));
        check({tag, ".din"},  32'(rf_din),  32'(d));
        check({tag, ".load"}, 32'(rf_load), 32'(ld));
        check({tag, ".busy"}, 32'(busy),    32'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; sw_data = 4'h9; sw_addr = 3'd4;
        btn_wr = 1'b0; btn_fill = 1'b0; scan_en = 1'b0;
        #1 clr = 1'b1;
        #1 chk_out("reset_async", 3'd0, 4'h0, 1'b0, 1'b0);
        tick(); tick();
        chk_out("reset_held", 3'd0, 4'h0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();
        chk_out("idle_after_reset", 3'd4, 4'h9, 1'b0, 1'b0);

        // 1: clear in the middle of a fill, button held through release
        sw_data = 4'h7; btn_fill = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("fill_pre_clr%0d", i), 3'(i), 4'(7 + i), 1'b1, 1'b1);
        end
        clr = 1'b1;
        #1 chk_out("clr_mid_fill", 3'd0, 4'h0, 1'b0, 1'b0);
        tick();
        chk_out("clr_mid_fill_held", 3'd0, 4'h0, 1'b0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("no_fill_after_clr%0d", i), 3'd4, 4'h7, 1'b0, 1'b0);
        end

        // 2: a 3-cycle write press gives one load cycle
        btn_fill = 1'b0; sw_addr = 3'd5; sw_data = 4'hA;
        tick();
        btn_wr = 1'b1;
        tick(); chk_out("write_load", 3'd5, 4'hA, 1'b1, 1'b1);
        tick(); chk_out("write_done1", 3'd5, 4'hA, 1'b0, 1'b0);
        tick(); chk_out("write_done2", 3'd5, 4'hA, 1'b0, 1'b0);
        btn_wr = 1'b0;
        tick(); chk_out("write_released", 3'd5, 4'hA, 1'b0, 1'b0);

        // 3: fill from 0xE wraps the data; switches changed after the edge are ignored
        sw_data = 4'hE; btn_fill = 1'b1;
        tick(); chk_out("fill_e0", 3'd0, 4'hE, 1'b1, 1'b1);
        sw_data = 4'h0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_out($sformatf("fill_e%0d", i), 3'(i), 4'(14 + i), 1'b1, 1'b1);
        end
        tick(); chk_out("fill_e_done", 3'd5, 4'h0, 1'b0, 1'b0);
        btn_fill = 1'b0;
        tick();

        // 4: simultaneous edges -> fill only; a write edge mid-fill is dropped
        sw_data = 4'h3; btn_wr = 1'b1; btn_fill = 1'b1;
        tick(); chk_out("both_fill0", 3'd0, 4'h3, 1'b1, 1'b1);
        btn_wr = 1'b0;
        tick(); chk_out("both_fill1", 3'd1, 4'h4, 1'b1, 1'b1);
        btn_wr = 1'b1;
        for (int i = 2; i < 8; i++) begin
            tick();
            chk_out($sformatf("both_fill%0d", i), 3'(i), 4'(3 + i), 1'b1, 1'b1);
        end
        tick(); chk_out("wr_dropped1", 3'd5, 4'h3, 1'b0, 1'b0);
        tick(); chk_out("wr_dropped2", 3'd5, 4'h3, 1'b0, 1'b0);
        btn_wr = 1'b0; btn_fill = 1'b0;

        // 5: scan steps every 4 cycles; a write freezes it for its cycle
        scan_en = 1'b1; ticks = 0;
        for (int n = 0; n < 39; n++) begin
            tick(); ticks++;
            check($sformatf("scan_addr_t%0d", ticks), 32'(rf_addr), 32'((ticks / 4) % 8));
            check($sformatf("scan_load_t%0d", ticks), 32'(rf_load), 32'd0);
        end
        btn_wr = 1'b1; sw_addr = 3'd6; sw_data = 4'h3;
        tick(); ticks++;
        chk_out("scan_write", 3'd6, 4'h3, 1'b1, 1'b1);
        btn_wr = 1'b0;
        tick();
        chk_out("scan_after_write", 3'((ticks / 4) % 8), 4'h3, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            tick(); ticks++;
            check($sformatf("scan_resume_t%0d", ticks), 32'(rf_addr), 32'((ticks / 4) % 8));
        end

        // 6: leaving scan follows switches; re-entering starts at 0
        scan_en = 1'b0; sw_addr = 3'd5;
        tick(); check("scan_off_a", 32'(rf_addr), 32'd5);
        sw_addr = 3'd2;
        tick(); check("scan_off_b", 32'(rf_addr), 32'd2);
        scan_en = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            check($sformatf("scan_restart%0d", n), 32'(rf_addr), (n < 4) ? 32'd0 : 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
